// File: rtl/xor_detector_filter.sv
// XOR phase detector followed by a K-counter loop filter.
// An up/down pair of modulo-K counters turns the detector output into carry/borrow pulses.
module xor_detector_filter #(
    parameter int K_BITS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic ref_signal,
    input  logic dco_signal,
    output logic out,
    output logic carry,
    output logic borrow
);

    localparam logic [K_BITS-1:0] CNT_ZERO = {K_BITS{1'b0}};
    localparam logic [K_BITS-1:0] CNT_ONE  = {{(K_BITS-1){1'b0}}, 1'b1};
    localparam logic [K_BITS-1:0] CNT_MAX  = {K_BITS{1'b1}};

    logic [K_BITS-1:0] up_cnt;
    logic [K_BITS-1:0] dn_cnt;
    logic [K_BITS-1:0] up_cnt_next;
    logic [K_BITS-1:0] dn_cnt_next;
    logic              carry_next;
    logic              borrow_next;

    // The detector is intentionally unregistered so the loop sees zero latency.
    assign out = ref_signal ^ dco_signal;

    // Next-state counting: only the counter selected by the detector moves; the other keeps its partial count.
    always_comb begin
        up_cnt_next = up_cnt;
        dn_cnt_next = dn_cnt;
        carry_next  = 1'b0;
        borrow_next = 1'b0;
        if (out) begin
            dn_cnt_next = dn_cnt - CNT_ONE;
            borrow_next = (dn_cnt == CNT_ZERO);
        end else begin
            up_cnt_next = up_cnt + CNT_ONE;
            carry_next  = (up_cnt == CNT_MAX);
        end
    end

    // Counter and pulse registers; reset overrides counting and clears any pulse in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            up_cnt <= CNT_ZERO;
            dn_cnt <= CNT_MAX;
            carry  <= 1'b0;
            borrow <= 1'b0;
        end else begin
            up_cnt <= up_cnt_next;
            dn_cnt <= dn_cnt_next;
            carry  <= carry_next;
            borrow <= borrow_next;
        end
    end

endmodule

// File: tb/tb_xor_detector_filter.sv
// Directed self-checking bench for xor_detector_filter with K_BITS=4 (K=16).
// Inputs change 1 ns after each rising edge; outputs are sampled at that same point.
module tb_xor_detector_filter;

    logic clk;
    logic reset;
    logic ref_signal;
    logic dco_signal;
    logic out;
    logic carry;
    logic borrow;

    int checks   = 0;
    int failures = 0;

    xor_detector_filter #(.K_BITS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .ref_signal (ref_signal),
        .dco_signal (dco_signal),
        .out        (out),
        .carry      (carry),
        .borrow     (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for four edges, then confirm the cleared state and release.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        repeat (4) tick();
        check({tag, "_rst_carry"}, {31'd0, carry}, 32'd0);
        check({tag, "_rst_borrow"}, {31'd0, borrow}, 32'd0);
        check({tag, "_rst_up"}, {28'd0, dut.up_cnt}, 32'd0);
        check({tag, "_rst_dn"}, {28'd0, dut.dn_cnt}, 32'd15);
        reset = 1'b0;
    endtask

    // Drive a fixed ref/dco pair for n edges; a pulse is expected only after edges p1 and p2.
    task automatic run_steady(input string tag, input logic r, input logic d,
                              input int n, input int p1, input int p2);
        logic up_dir;
        up_dir = ~(r ^ d);
        ref_signal = r;
        dco_signal = d;
        for (int c = 1; c <= n; c++) begin
            tick();
            check({tag, "_carry"}, {31'd0, carry},
                  {31'd0, up_dir & ((c == p1) | (c == p2))});
            check({tag, "_borrow"}, {31'd0, borrow},
                  {31'd0, ~up_dir & ((c == p1) | (c == p2))});
        end
    endtask

    initial begin
        int carries;
        int borrows;
        int coincident;
        int ones;
        int phase;

        reset      = 1'b1;
        ref_signal = 1'b0;
        dco_signal = 1'b0;

        // Combinational detector truth table, checked without waiting for a clock edge.
        ref_signal = 1'b1; dco_signal = 1'b0; #1;
        check("out_10", {31'd0, out}, 32'd1);
        ref_signal = 1'b1; dco_signal = 1'b1; #1;
        check("out_11", {31'd0, out}, 32'd0);
        ref_signal = 1'b0; dco_signal = 1'b1; #1;
        check("out_01", {31'd0, out}, 32'd1);
        ref_signal = 1'b0; dco_signal = 1'b0; #1;
        check("out_00", {31'd0, out}, 32'd0);

        // Steady out=0: carries after counting edges 16 and 32, no borrow.
        do_reset("up40");
        run_steady("up40", 1'b0, 1'b0, 40, 16, 32);

        // Steady out=1: borrows after counting edges 16 and 32, no carry.
        ref_signal = 1'b1; dco_signal = 1'b0;
        do_reset("dn40");
        run_steady("dn40", 1'b1, 1'b0, 40, 16, 32);

        // Partial counts survive a direction change.
        do_reset("mix");
        run_steady("mix_a", 1'b1, 1'b1, 10, 0, 0);
        check("mix_up10", {28'd0, dut.up_cnt}, 32'd10);
        run_steady("mix_b", 1'b0, 1'b1, 10, 0, 0);
        check("mix_up_held", {28'd0, dut.up_cnt}, 32'd10);
        check("mix_dn5", {28'd0, dut.dn_cnt}, 32'd5);
        run_steady("mix_c", 1'b0, 1'b0, 6, 6, 0);
        check("mix_up_wrap", {28'd0, dut.up_cnt}, 32'd0);
        check("mix_dn_held", {28'd0, dut.dn_cnt}, 32'd5);

        // Reset asserted while carry is high clears it and restarts the count.
        do_reset("rc");
        run_steady("rc_a", 1'b0, 1'b0, 16, 16, 0);
        reset = 1'b1;
        tick();
        check("rc_carry_clr", {31'd0, carry}, 32'd0);
        check("rc_up", {28'd0, dut.up_cnt}, 32'd0);
        check("rc_dn", {28'd0, dut.dn_cnt}, 32'd15);
        reset = 1'b0;
        run_steady("rc_b", 1'b0, 1'b0, 17, 16, 0);

        // Reset asserted while borrow is high behaves the same way.
        do_reset("rb");
        run_steady("rb_a", 1'b0, 1'b1, 16, 16, 0);
        reset = 1'b1;
        tick();
        check("rb_borrow_clr", {31'd0, borrow}, 32'd0);
        check("rb_dn", {28'd0, dut.dn_cnt}, 32'd15);
        reset = 1'b0;
        run_steady("rb_b", 1'b0, 1'b1, 16, 16, 0);

        // Quadrature: 30-cycle steps, phases 00,10,11,01, 10 repetitions = 1200 edges.
        do_reset("quad");
        carries    = 0;
        borrows    = 0;
        coincident = 0;
        ones       = 0;
        for (int i = 0; i < 1200; i++) begin
            phase      = (i / 30) % 4;
            ref_signal = (phase == 1) || (phase == 2);
            dco_signal = (phase == 2) || (phase == 3);
            if (out) ones++;
            tick();
            if (carry) carries++;
            if (borrow) borrows++;
            if (carry && borrow) coincident++;
        end
        // 600 out=0 edges and 600 out=1 edges from a fresh reset give 37 wraps each.
        check("quad_duty", ones, 32'd600);
        check("quad_carries", carries, 32'd37);
        check("quad_borrows", borrows, 32'd37);
        check("quad_coincident", coincident, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xor_detector_filter.md
XOR_DETECTOR_FILTER -- requirements
Module: xor_detector_filter

Interface
REQ-001 Parameter: K_BITS, default 4, counter width; modulus K = 2^K_BITS (default K=16); legal range 2..16.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 ref_signal  input  1  reference square wave, asynchronous to clk.
REQ-005 dco_signal  input  1  DCO feedback square wave, asynchronous to clk.
REQ-006 out  output  1  phase-detector output = ref_signal XOR dco_signal.
REQ-007 carry  output  1  registered one-cycle pulse; up-count overflow (phase-advance request).
REQ-008 borrow  output  1  registered one-cycle pulse; down-count underflow (phase-retard request).

Function
REQ-009 out SHALL be purely combinational (ref_signal XOR dco_signal), zero latency, unaffected by reset and clk.
REQ-010 The filter SHALL be a K-counter with two internal K_BITS registers: up_cnt and dn_cnt.
REQ-011 Each non-reset rising edge SHALL sample out directly; no synchronizer, no added latency.
REQ-012 Sampled out=0: up_cnt <= (up_cnt+1) mod K; dn_cnt holds.
REQ-013 Sampled out=1: dn_cnt <= (dn_cnt-1) mod K; up_cnt holds.
REQ-014 carry SHALL be 1 in the cycle after an edge where out=0 and up_cnt==K-1 (wrap K-1 -> 0), else 0.
REQ-015 borrow SHALL be 1 in the cycle after an edge where out=1 and dn_cnt==0 (wrap 0 -> K-1), else 0.
REQ-016 carry and borrow SHALL never be 1 simultaneously; each pulse lasts exactly one clk cycle.
REQ-017 Steady out=0 SHALL yield one carry every K cycles; steady out=1 one borrow every K cycles.
REQ-018 Direction change SHALL NOT clear the inactive counter; partial counts persist.
REQ-019 Wrap-around SHALL be modulo K with no saturation; back-to-back periods produce pulses exactly K cycles apart.
REQ-020 Unknown (X) on out SHALL be tolerated in simulation: counters may go X but SHALL recover on reset; synthesis semantics are as REQ-012/013.

Reset
REQ-021 reset=1 at a rising edge: up_cnt <= 0, dn_cnt <= K-1, carry <= 0, borrow <= 0.
REQ-022 reset SHALL take priority over counting, including when asserted mid-count or during a carry/borrow pulse (pulse cleared next edge).
REQ-023 After reset, first carry (steady out=0) SHALL appear after exactly K counting edges; same for first borrow (steady out=1).

Verification
REQ-024 ref=1, dco=0 -> out=1 immediately; ref=1, dco=1 -> out=0; ref=0, dco=1 -> out=1; ref=0, dco=0 -> out=0.
REQ-025 K_BITS=4, reset 4 cycles then out held 0 for 40 cycles -> carry high on cycles 16 and 32 after reset release, borrow never high.
REQ-026 K_BITS=4, out held 1 for 40 cycles after reset -> borrow high on cycles 16 and 32, carry never high.
REQ-027 Quadrature stimulus (ref/dco toggling, 300 ns steps, 10 ns clk, 10 repetitions) -> 50% out duty; carry and borrow counts each within +/-1 over run; never coincident.
REQ-028 out=0 for 10 cycles, out=1 for 10, out=0 for 6 -> no pulse until the 16th out=0 edge, then single carry; up_cnt retained across the out=1 interval.
REQ-029 Assert reset on the cycle carry is high -> carry 0 next cycle; counters at 0/K-1; next carry after a further K out=0 edges.
